// File: rtl/user_uart_pkg.sv
// rtl/user_uart_pkg.sv - shared types and status-word layout for the user UART transmitter
package user_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int ST_FULL    = 8;
    localparam int ST_EMPTY   = 9;
    localparam int ST_BUSY    = 10;
    localparam int ST_CNT_LSB = 16;
    localparam int ST_CNT_W   = 5;

endpackage

// File: rtl/naive_bus.sv
// rtl/naive_bus.sv - simple request/grant bus with separate read and write channels
interface naive_bus;

    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [3:0]  wr_byte;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_byte, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_byte, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );

endinterface

// File: rtl/user_uart_tx_slave_sync_fifo.sv
// rtl/user_uart_tx_slave_sync_fifo.sv - single-clock FIFO with registered read data
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rdata;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_rdata;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdata <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rdata <= r_mem[r_rptr];
                r_rptr  <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/user_uart_tx_slave.sv
// rtl/user_uart_tx_slave.sv - bus slave that queues bytes and sends them as 8N1 UART frames
module user_uart_tx_slave #(
    parameter int UART_TX_CLK_DIV = 434,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    naive_bus.slave  bus,
    output logic     o_uart_tx
);

    import user_uart_pkg::*;

    localparam int BW = (UART_TX_CLK_DIV > 2) ? $clog2(UART_TX_CLK_DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(UART_TX_CLK_DIV - 1);

    tx_state_t        r_state;
    logic [BW-1:0]    r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic [31:0]      r_rd_data;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bit_end;
    logic [7:0]       w_fifo_rdata;
    logic [CW-1:0]    w_count;
    logic [31:0]      w_count_ext;
    logic [ST_CNT_W-1:0] w_cnt_field;
    logic [31:0]      w_status;
    logic             w_unused_bus;

    assign bus.wr_gnt = rst_n && bus.wr_req && !w_full;
    assign bus.rd_gnt = rst_n && bus.rd_req;
    assign bus.rd_data = r_rd_data;
    assign o_uart_tx  = r_tx;

    assign w_push    = bus.wr_gnt && bus.wr_byte[0];
    assign w_bit_end = (r_baud == '0);
    assign w_pop     = !w_empty && ((r_state == IDLE) || (r_state == STOP && w_bit_end));

    assign w_unused_bus = ^{bus.rd_addr, bus.wr_addr, bus.wr_data[31:8], bus.wr_byte[3:1]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (bus.wr_data[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Popped byte appears on the FIFO read port one cycle later, so it is
    // captured into the shift register when the start bit finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            if (r_state != IDLE) begin
                r_baud <= w_bit_end ? BAUD_LOAD : r_baud - 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= START;
                        r_baud  <= BAUD_LOAD;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_shift   <= w_fifo_rdata;
                        r_bit_idx <= '0;
                        r_tx      <= w_fifo_rdata[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (!w_empty) begin
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign w_count_ext = 32'(w_count);
    assign w_cnt_field = (w_count_ext > 32'd31) ? 5'd31 : w_count_ext[ST_CNT_W-1:0];

    always_comb begin
        w_status = '0;
        w_status[ST_CNT_LSB +: ST_CNT_W] = w_cnt_field;
        w_status[ST_BUSY]  = (r_state != IDLE);
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_FULL]  = w_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (bus.rd_gnt) begin
            r_rd_data <= w_status;
        end
    end

endmodule

// File: doc/user_uart_tx_slave.md
Name: user_uart_tx_slave

Overview:
- naive_bus slave occupying the user-UART window 0x0003_0000–0x0003_0003 (router mask 0x3).
- The core writes bytes into a TX FIFO, and the block serialises them as 8N1 UART frames on o_uart_tx.
- A status word is readable over the same bus.
- It is the responder/transmitter end for the core's data-master writes to the user UART.

Parameters:
- UART_TX_CLK_DIV, 434: clk cycles per UART bit (50 MHz / 115200 Hz). Legal range ≥2.
- FIFO_DEPTH, 16: TX FIFO entries. Must be a power of 2 and ≥2.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- bus  naive_bus.slave  –  slave side of the bus. Fields used: rd_req, rd_gnt, rd_addr[31:0], rd_data[31:0], wr_req, wr_gnt, wr_addr[31:0], wr_byte[3:0], wr_data[31:0].
- o_uart_tx  output  1  UART TX line, idle high.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low. All state is cleared immediately on assertion.
- Reset values:
  - o_uart_tx=1, FIFO empty (count=0), FSM=IDLE, baud counter=0.
  - rd_data=0; rd_gnt and wr_gnt are 0 while in reset.
- Address decoding: addr[1:0] are ignored, so the whole window is a single register.
- Write path:
  - wr_gnt = wr_req && !fifo_full, combinational. When the FIFO is full the master is stalled.
  - A granted write with wr_byte[0]=1 pushes wr_data[7:0]. A granted write with wr_byte[0]=0 is accepted and discarded.
  - Fullness is evaluated on the current state only: a pop in the same cycle does not free a slot for that cycle's write.
- Read path:
  - rd_gnt = rd_req, combinational.
  - rd_data is registered and valid in the cycle after the grant.
  - Status word layout:
    - [31:21] 0
    - [20:16] fifo count (saturating width clog2(FIFO_DEPTH)+1)
    - [15:11] 0
    - [10] tx_busy (FSM≠IDLE)
    - [9] fifo_empty
    - [8] fifo_full
    - [7:0] 0
  - When rd_gnt=0, rd_data holds its last value.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_uart_tx=1. If the FIFO is non-empty: pop into the shift register, load the baud counter with DIV-1, go to START.
  - START: o_uart_tx=0 for DIV cycles, then load bit index 0 and go to DATA.
  - DATA: o_uart_tx = shift[0], LSB first, for DIV cycles per bit. After bit 7, go to STOP.
  - STOP: o_uart_tx=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no extra idle bit). Otherwise go to IDLE.
- Frame timing:
  - One frame is exactly 10×DIV cycles.
  - A write granted in cycle N into an idle, empty block puts the start bit on o_uart_tx from cycle N+2.
  - o_uart_tx is driven from a flop (glitch-free).
- Baud counter: counts down from DIV-1 to 0. The bit ends when the counter is 0. Width is clog2(DIV).
- Simultaneous push into an empty FIFO and IDLE pop: impossible by construction, because IDLE samples the registered count. The push is seen next cycle.
- Reset mid-frame: the line returns high immediately and the FIFO is flushed. No partial frame resumes after release.

Decomposition:
- Package user_uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Status bit-position localparams: ST_FULL=8, ST_EMPTY=9, ST_BUSY=10, ST_CNT_LSB=16.
- Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH):
  - Registered read data, plus full/empty/count outputs.
  - Same clock and asynchronous active-low reset as the parent.
  - Push while full and pop while empty are ignored.

Test Plan:
- Reset, then read → rd_data = 0x0000_0200 (empty only). o_uart_tx = 1.
- DIV=4. Write 0x55 with wr_byte=4'b0001, granted in cycle N → o_uart_tx is:
  - 0 for cycles N+2..N+5 (start bit),
  - then 1,0,1,0,1,0,1,0 at 4 cycles each,
  - then 1 (stop),
  - then idle at N+42.
  - A read during the frame returns bit10=1.
- DIV=4, DEPTH=4. Six back-to-back writes → five are granted consecutively (the first is popped at N+1). The sixth sees wr_gnt=0 until the second byte is popped at the end of frame 1 (40 cycles after the start bit).
- Write 0xA3 with wr_byte=4'b0010 → wr_gnt=1, count stays 0, no start bit appears.
- Two queued bytes 0x01, 0x80 → the stop bit of frame 1 is followed immediately by the start bit of frame 2. Total busy time is 80 cycles (DIV=4).
- Assert rst_n low mid-DATA of frame 1 with 3 bytes queued → o_uart_tx=1 in the same cycle. After release, status reads 0x0000_0200 and the line stays high.
